// File: rtl/const_bank_if.sv
// Bus bundle for const_bank: write port, read select, step controls and the
// registered constant output. ADDR_W must match the bank's derived index width.
interface const_bank_if #(
  parameter int WIDTH  = 3,
  parameter int ADDR_W = 3
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;
  logic [ADDR_W-1:0] sel;
  logic              step_mode;
  logic              step;
  logic              step_clr;
  logic [WIDTH-1:0]  A;
  logic              valid;
  logic [ADDR_W-1:0] ptr;

  modport master (
    output we, waddr, wdata, sel, step_mode, step, step_clr,
    input  A, valid, ptr
  );

  modport slave (
    input  we, waddr, wdata, sel, step_mode, step, step_clr,
    output A, valid, ptr
  );
endinterface

// File: rtl/const_bank.sv
// Programmable constant bank with a registered, write-first selected output.
// Define CONST_STEP_EN to add the auto-sequencing pointer (ptr/step/step_clr).
module const_bank #(
  parameter int               WIDTH = 3,
  parameter int               DEPTH = 8,
  parameter logic [WIDTH-1:0] BASE  = 3'b110
) (
  input logic         clk,
  input logic         rst,
  const_bank_if.slave bus
);
  localparam int              ADDR_W  = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] bank;
  logic [WIDTH-1:0]            a_q;
  logic                        valid_q;
  logic [WIDTH-1:0]            rd_data;
  logic [ADDR_W-1:0]           ridx;
  logic                        wr_ok;
  logic                        rd_ok;

  // Indices past DEPTH-1 exist whenever DEPTH is not a power of two.
  assign wr_ok = bus.we && ({1'b0, bus.waddr} < DEPTH_L);
  assign rd_ok = ({1'b0, ridx} < DEPTH_L);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        bank[i] <= WIDTH'(int'(BASE) + i);
    end else if (wr_ok) begin
      bank[bus.waddr] <= bus.wdata;
    end
  end

  always_comb begin
    rd_data = BASE;
    if (rd_ok)
      rd_data = (wr_ok && (bus.waddr == ridx)) ? bus.wdata : bank[ridx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= BASE;
      valid_q <= 1'b0;
    end else begin
      a_q     <= rd_data;
      valid_q <= 1'b1;
    end
  end

  assign bus.A     = a_q;
  assign bus.valid = valid_q;

`ifdef CONST_STEP_EN
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  logic [ADDR_W-1:0] ptr_q;

  // Pointer advances independently of step_mode; reads use the pre-update value.
  always_ff @(posedge clk) begin
    if (rst || bus.step_clr) ptr_q <= '0;
    else if (bus.step)       ptr_q <= (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
  end

  assign ridx    = bus.step_mode ? ptr_q : bus.sel;
  assign bus.ptr = ptr_q;
`else
  logic unused_step;
  assign unused_step = ^{bus.step_mode, bus.step, bus.step_clr};
  assign ridx        = bus.sel;
  assign bus.ptr     = '0;
`endif
endmodule

// File: tb/tb_const_bank.sv
// Self-checking bench for const_bank (DEPTH=6): directed cases plus random
// traffic against an array-based reference model of the bank.
module tb_const_bank;
  localparam int               WIDTH  = 3;
  localparam int               DEPTH  = 6;
  localparam int               ADDR_W = 3;
  localparam logic [WIDTH-1:0] BASE   = 3'b110;
`ifdef CONST_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  const_bank_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  const_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BASE(BASE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  int m_bank[DEPTH];
  int m_a;
  int m_valid;
  int m_ptr;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle, advance the model on the edge, then compare.
  task automatic tick(input bit r, input bit w, input int wa, input int wd,
                      input int s, input bit sm, input bit st, input bit sc);
    int ridx;
    rst           = r;
    bus.we        = w;
    bus.waddr     = ADDR_W'(wa);
    bus.wdata     = WIDTH'(wd);
    bus.sel       = ADDR_W'(s);
    bus.step_mode = sm;
    bus.step      = st;
    bus.step_clr  = sc;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < DEPTH; i++) m_bank[i] = (int'(BASE) + i) % (1 << WIDTH);
      m_a     = int'(BASE);
      m_valid = 0;
      m_ptr   = 0;
    end else begin
      ridx = (STEP_EN && sm) ? m_ptr : s;
      if (ridx >= DEPTH)            m_a = int'(BASE);
      else if (w && wa == ridx)     m_a = wd;
      else                          m_a = m_bank[ridx];
      if (w && wa < DEPTH) m_bank[wa] = wd;
      m_valid = 1;
      if (STEP_EN) begin
        if (sc)      m_ptr = 0;
        else if (st) m_ptr = (m_ptr + 1) % DEPTH;
      end
    end
    #1;
    chk("A",     int'(bus.A),     m_a);
    chk("valid", int'(bus.valid), m_valid);
    chk("ptr",   int'(bus.ptr),   m_ptr);
  endtask

  initial begin
    // Reset defaults and release
    tick(1, 0, 0, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_A_const", int'(bus.A), 6);
    tick(0, 0, 0, 0, 0, 0, 0, 0);
    chk("rel_valid_const", int'(bus.valid), 1);
    tick(0, 0, 0, 0, 3, 0, 0, 0);
    chk("sel3_const", int'(bus.A), 1);

    // Write then read, bypass collision
    tick(0, 1, 5, 2, 2, 0, 0, 0);
    chk("sel2_const", int'(bus.A), 0);
    tick(0, 0, 0, 0, 5, 0, 0, 0);
    chk("rd5_const", int'(bus.A), 2);
    tick(0, 1, 4, 7, 4, 0, 0, 0);
    chk("bypass_const", int'(bus.A), 7);

    // Out-of-range write dropped, out-of-range read gives BASE
    tick(0, 1, 7, 3, 7, 0, 0, 0);
    chk("oor_rd_const", int'(bus.A), 6);
    for (int i = 0; i < DEPTH; i++) tick(0, 0, 0, 0, i, 0, 0, 0);

    // Mid-operation reset overwrites earlier writes
    tick(0, 1, 1, 0, 1, 0, 0, 0);
    tick(0, 0, 0, 0, 1, 0, 0, 0);
    chk("wr1_const", int'(bus.A), 0);
    tick(1, 1, 1, 5, 1, 0, 1, 0);
    chk("midrst_valid_const", int'(bus.valid), 0);
    tick(0, 0, 0, 0, 1, 0, 0, 0);
    chk("post_rst_const", int'(bus.A), 7);
    chk("post_rst_valid_const", int'(bus.valid), 1);

    // Stepping (with macro off, A follows sel and ptr stays 0)
    tick(0, 0, 0, 0, 2, 0, 0, 1);
    for (int i = 0; i < 9; i++) tick(0, 0, 0, 0, 2, 1, 1, 0);
    tick(0, 0, 0, 0, 2, 1, 1, 1);
    chk("clr_ptr_const", int'(bus.ptr), 0);
    tick(0, 0, 0, 0, 2, 1, 0, 0);

    // Random traffic
    for (int n = 0; n < 400; n++)
      tick(($urandom_range(0, 39) == 0), $urandom_range(0, 1),
           $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 7) == 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
